// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
package alu_arb_pkg;

   localparam int unsigned SEL_W = 3;
   localparam int unsigned CNT_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WAIT    = 2'd1,
      ST_CAPTURE = 2'd2
   } state_t;

   typedef enum logic [SEL_W-1:0] {
      ALU_ADD = 3'd0,
      ALU_SUB = 3'd1,
      ALU_AND = 3'd2,
      ALU_OR  = 3'd3,
      ALU_XOR = 3'd4,
      ALU_NOT = 3'd5,
      ALU_SHL = 3'd6,
      ALU_SHR = 3'd7
   } alu_fn_t;

endpackage

// File: rtl/alu_arb_grant.sv
// One-hot grant select for two requesters; round-robin on last-granted,
// or fixed priority to requester 0 when ALU_ARB_FIXED_PRIO_EN is defined.
module alu_arb_grant (
   input  logic       i_req0,
   input  logic       i_req1,
   input  logic       i_last,
   output logic [1:0] o_grant_c
);

`ifdef ALU_ARB_FIXED_PRIO_EN
   logic w_unused_last;
   assign w_unused_last = i_last;

   always_comb begin
      o_grant_c = 2'b00;
      if (i_req0)      o_grant_c = 2'b01;
      else if (i_req1) o_grant_c = 2'b10;
   end
`else
   always_comb begin
      o_grant_c = {i_req1, i_req0};
      // Contention goes to whoever was not served last.
      if (i_req0 && i_req1) o_grant_c = i_last ? 2'b01 : 2'b10;
   end
`endif

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two requesters onto one shared external ALU, one op in flight.
// Build option: ALU_ARB_FIXED_PRIO_EN selects fixed priority (requester 0).
module alu_arbiter
   import alu_arb_pkg::*;
#(
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned ALU_WAIT = 1
) (
   input  logic              CLK,
   input  logic              RESET_N,
   input  logic              REQ0,
   input  logic              REQ1,
   input  logic [DATA_W-1:0] OPA0,
   input  logic [DATA_W-1:0] OPB0,
   input  logic [DATA_W-1:0] OPA1,
   input  logic [DATA_W-1:0] OPB1,
   input  logic [SEL_W-1:0]  SEL0,
   input  logic [SEL_W-1:0]  SEL1,
   output logic              ACK0,
   output logic              ACK1,
   output logic              DONE0,
   output logic              DONE1,
   output logic [DATA_W-1:0] RES,
   output logic [DATA_W-1:0] ALU_DATA1,
   output logic [DATA_W-1:0] ALU_DATA2,
   output logic [SEL_W-1:0]  ALU_SELECT,
   input  logic [DATA_W-1:0] ALU_RESULT,
   output logic              BUSY
);

   state_t              r_state;
   state_t              w_state_nxt;
   logic [CNT_W-1:0]    r_cnt;
   logic [CNT_W-1:0]    w_cnt_nxt;
   logic                r_last;
   logic                w_last_nxt;
   logic                r_gnt_id;
   logic                w_gnt_id_nxt;
   logic [1:0]          r_ack;
   logic [1:0]          w_ack_nxt;
   logic [1:0]          r_done;
   logic [1:0]          w_done_nxt;
   logic                r_busy;
   logic                w_load;
   logic                w_cap;
   logic [1:0]          w_grant;
   logic [DATA_W-1:0]   r_res;
   logic [DATA_W-1:0]   r_alu_data1;
   logic [DATA_W-1:0]   r_alu_data2;
   logic [SEL_W-1:0]    r_alu_select;

   alu_arb_grant u_grant (
      .i_req0    (REQ0),
      .i_req1    (REQ1),
      .i_last    (r_last),
      .o_grant_c (w_grant)
   );

   // State register
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) r_state <= ST_IDLE;
      else          r_state <= w_state_nxt;
   end

   // Next-state and control decode
   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_last_nxt   = r_last;
      w_gnt_id_nxt = r_gnt_id;
      w_ack_nxt    = 2'b00;
      w_done_nxt   = 2'b00;
      w_load       = 1'b0;
      w_cap        = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (|w_grant) begin
               w_load       = 1'b1;
               w_ack_nxt    = w_grant;
               w_cnt_nxt    = CNT_W'(ALU_WAIT);
               w_gnt_id_nxt = w_grant[1];
               w_last_nxt   = w_grant[1];
               w_state_nxt  = ST_WAIT;
            end
         end
         ST_WAIT: begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) w_state_nxt = ST_CAPTURE;
         end
         ST_CAPTURE: begin
            w_cap       = 1'b1;
            w_done_nxt  = r_gnt_id ? 2'b10 : 2'b01;
            w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Registered control, operands and result
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_cnt        <= '0;
         r_last       <= 1'b1;
         r_gnt_id     <= 1'b0;
         r_ack        <= 2'b00;
         r_done       <= 2'b00;
         r_busy       <= 1'b0;
         r_res        <= '0;
         r_alu_data1  <= '0;
         r_alu_data2  <= '0;
         r_alu_select <= '0;
      end else begin
         r_cnt    <= w_cnt_nxt;
         r_last   <= w_last_nxt;
         r_gnt_id <= w_gnt_id_nxt;
         r_ack    <= w_ack_nxt;
         r_done   <= w_done_nxt;
         r_busy   <= (w_state_nxt != ST_IDLE);
         if (w_load) begin
            r_alu_data1  <= w_grant[1] ? OPA1 : OPA0;
            r_alu_data2  <= w_grant[1] ? OPB1 : OPB0;
            r_alu_select <= w_grant[1] ? SEL1 : SEL0;
         end
         if (w_cap) r_res <= ALU_RESULT;
      end
   end

   assign ACK0       = r_ack[0];
   assign ACK1       = r_ack[1];
   assign DONE0      = r_done[0];
   assign DONE1      = r_done[1];
   assign BUSY       = r_busy;
   assign RES        = r_res;
   assign ALU_DATA1  = r_alu_data1;
   assign ALU_DATA2  = r_alu_data2;
   assign ALU_SELECT = r_alu_select;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: one instance at ALU_WAIT=1, one at ALU_WAIT=4.
module tb_alu_arbiter;

   logic       CLK = 1'b0;
   logic       RESET_N = 1'b0;

   // Instance A (ALU_WAIT=1)
   logic       req0_a = 1'b0, req1_a = 1'b0;
   logic [7:0] opa0_a = '0, opb0_a = '0, opa1_a = '0, opb1_a = '0;
   logic [2:0] sel0_a = '0, sel1_a = '0;
   logic       ack0_a, ack1_a, done0_a, done1_a, busy_a;
   logic [7:0] res_a, d1_a, d2_a, alu_res_a;
   logic [2:0] asel_a;

   // Instance B (ALU_WAIT=4), requester 1 unused
   logic       req0_b = 1'b0;
   logic [7:0] opa0_b = '0, opb0_b = '0;
   logic [2:0] sel0_b = '0;
   logic       ack0_b, ack1_b, done0_b, done1_b, busy_b;
   logic [7:0] res_b, d1_b, d2_b, alu_res_b;
   logic [2:0] asel_b;

   int checks = 0;
   int failures = 0;
   logic excl_viol = 1'b0;

   always #5 CLK = ~CLK;

   function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                        input logic [2:0] s);
      case (s)
         3'd0: return a + b;
         3'd1: return a - b;
         3'd2: return a & b;
         3'd3: return a | b;
         3'd4: return a ^ b;
         3'd5: return ~a;
         3'd6: return a << 1;
         default: return a >> 1;
      endcase
   endfunction

   assign alu_res_a = alu_f(d1_a, d2_a, asel_a);
   assign alu_res_b = alu_f(d1_b, d2_b, asel_b);

   alu_arbiter #(.DATA_W(8), .ALU_WAIT(1)) u_dut_a (
      .CLK(CLK), .RESET_N(RESET_N),
      .REQ0(req0_a), .REQ1(req1_a),
      .OPA0(opa0_a), .OPB0(opb0_a), .OPA1(opa1_a), .OPB1(opb1_a),
      .SEL0(sel0_a), .SEL1(sel1_a),
      .ACK0(ack0_a), .ACK1(ack1_a), .DONE0(done0_a), .DONE1(done1_a),
      .RES(res_a), .ALU_DATA1(d1_a), .ALU_DATA2(d2_a), .ALU_SELECT(asel_a),
      .ALU_RESULT(alu_res_a), .BUSY(busy_a)
   );

   alu_arbiter #(.DATA_W(8), .ALU_WAIT(4)) u_dut_b (
      .CLK(CLK), .RESET_N(RESET_N),
      .REQ0(req0_b), .REQ1(1'b0),
      .OPA0(opa0_b), .OPB0(opb0_b), .OPA1(8'h00), .OPB1(8'h00),
      .SEL0(sel0_b), .SEL1(3'd0),
      .ACK0(ack0_b), .ACK1(ack1_b), .DONE0(done0_b), .DONE1(done1_b),
      .RES(res_b), .ALU_DATA1(d1_b), .ALU_DATA2(d2_b), .ALU_SELECT(asel_b),
      .ALU_RESULT(alu_res_b), .BUSY(busy_b)
   );

   always @(negedge CLK) begin
      if ((ack0_a && ack1_a) || (done0_a && done1_a) ||
          (ack0_b && ack1_b) || (done0_b && done1_b))
         excl_viol = 1'b1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      int ack_ids[$];
      int ack_cyc[$];
      int done_ids[$];
      logic [7:0] done_res[$];
      int exp_id;
      logic [7:0] exp_res;
      logic saw_done;

      // Reset values
      tick(); tick();
      check("rst_ack0", ack0_a, 0);
      check("rst_done0", done0_a, 0);
      check("rst_busy", busy_a, 0);
      check("rst_res", res_a, 0);
      check("rst_d1", d1_a, 0);
      check("rst_sel", asel_a, 0);

      // Single AND op, ALU_WAIT=1
      RESET_N = 1'b1;
      req0_a = 1'b1; opa0_a = 8'hF0; opb0_a = 8'h3C; sel0_a = 3'd2;
      tick();
      check("t1_ack0", ack0_a, 1);
      check("t1_ack1", ack1_a, 0);
      check("t1_busy", busy_a, 1);
      check("t1_d1", d1_a, 8'hF0);
      check("t1_d2", d2_a, 8'h3C);
      check("t1_sel", asel_a, 3'd2);
      req0_a = 1'b0;
      tick();
      check("t1_ack0_off", ack0_a, 0);
      check("t1_nodone_early", done0_a, 0);
      tick();
      check("t1_done0", done0_a, 1);
      check("t1_done1", done1_a, 0);
      check("t1_res", res_a, 8'h30);
      check("t1_busy_idle", busy_a, 0);
      tick();
      check("t1_done0_pulse", done0_a, 0);
      check("t1_res_hold", res_a, 8'h30);

      // Request withdrawn before any edge: no grant
      #2 req0_a = 1'b1;
      #2 req0_a = 1'b0;
      tick();
      check("t2_noack", ack0_a, 0);
      check("t2_nobusy", busy_a, 0);

      // Dual continuous requests from reset
      RESET_N = 1'b0;
      tick();
      RESET_N = 1'b1;
      opa0_a = 8'h05; opb0_a = 8'h03; sel0_a = 3'd0;
      opa1_a = 8'h09; opb1_a = 8'h04; sel1_a = 3'd1;
      req0_a = 1'b1; req1_a = 1'b1;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (ack0_a) begin ack_ids.push_back(0); ack_cyc.push_back(i); end
         if (ack1_a) begin ack_ids.push_back(1); ack_cyc.push_back(i); end
         if (done0_a) begin done_ids.push_back(0); done_res.push_back(res_a); end
         if (done1_a) begin done_ids.push_back(1); done_res.push_back(res_a); end
      end
      req0_a = 1'b0; req1_a = 1'b0;
      check("rr_ack_count", ack_ids.size(), 4);
      check("rr_done_count", done_ids.size(), 4);
      for (int k = 0; k < 4; k++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
         exp_id = 0;
`else
         exp_id = k % 2;
`endif
         exp_res = (exp_id == 0) ? 8'h08 : 8'h05;
         if (k < ack_ids.size()) begin
            check($sformatf("rr_ack_id%0d", k), ack_ids[k], exp_id);
            check($sformatf("rr_ack_cyc%0d", k), ack_cyc[k], 3 * k);
         end
         if (k < done_ids.size()) begin
            check($sformatf("rr_done_id%0d", k), done_ids[k], exp_id);
            check($sformatf("rr_done_res%0d", k), done_res[k], exp_res);
         end
      end
      tick(); tick();

      // Lone REQ1, dropped right after ACK1
      RESET_N = 1'b0;
      tick();
      RESET_N = 1'b1;
      req1_a = 1'b1; opa1_a = 8'hAA; opb1_a = 8'h0F; sel1_a = 3'd4;
      tick();
      check("t4_ack1", ack1_a, 1);
      check("t4_ack0", ack0_a, 0);
      req1_a = 1'b0;
      tick();
      tick();
      check("t4_done1", done1_a, 1);
      check("t4_done0", done0_a, 0);
      check("t4_res", res_a, 8'hA5);

      // ALU_WAIT=4: operands stable through WAIT, DONE 5 edges after accept
      req0_b = 1'b1; opa0_b = 8'h12; opb0_b = 8'h34; sel0_b = 3'd3;
      tick();
      check("w4_ack0", ack0_b, 1);
      req0_b = 1'b0;
      opa0_b = 8'hFF; opb0_b = 8'hFF; sel0_b = 3'd7;
      for (int k = 1; k <= 4; k++) begin
         tick();
         check($sformatf("w4_d1_%0d", k), d1_b, 8'h12);
         check($sformatf("w4_d2_%0d", k), d2_b, 8'h34);
         check($sformatf("w4_sel_%0d", k), asel_b, 3'd3);
         check($sformatf("w4_nodone_%0d", k), done0_b, 0);
         check($sformatf("w4_busy_%0d", k), busy_b, 1);
      end
      tick();
      check("w4_done0", done0_b, 1);
      check("w4_res", res_b, 8'h36);

      // Asynchronous reset while in WAIT
      tick();
      req0_b = 1'b1; opa0_b = 8'h0F; opb0_b = 8'h01; sel0_b = 3'd0;
      tick();
      check("ar_ack0", ack0_b, 1);
      req0_b = 1'b0;
      tick();
      #3 RESET_N = 1'b0;
      #1;
      check("ar_busy", busy_b, 0);
      check("ar_d1", d1_b, 0);
      check("ar_d2", d2_b, 0);
      check("ar_sel", asel_b, 0);
      check("ar_res", res_b, 0);
      check("ar_ack0_rst", ack0_b, 0);
      tick();
      RESET_N = 1'b1;
      saw_done = 1'b0;
      for (int k = 0; k < 8; k++) begin
         tick();
         if (done0_b || done1_b || busy_b) saw_done = 1'b1;
      end
      check("ar_no_done", saw_done, 0);

      check("ack_done_exclusive", excl_viol, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter DATA_W, default 8: operand/result width.
REQ-002 Parameter ALU_WAIT, default 1: cycles held between operand issue and result capture; legal range 1..15.
REQ-003 CLK  input  1  sole clock, rising edge.
REQ-004 RESET_N  input  1  reset, asynchronous, active-low.
REQ-005 REQ0, REQ1  input  1 each  operation request from requester 0/1.
REQ-006 OPA0, OPB0, OPA1, OPB1  input  DATA_W each  operands of requester 0/1.
REQ-007 SEL0, SEL1  input  3 each  ALU function select of requester 0/1.
REQ-008 ACK0, ACK1  output  1 each  one-cycle pulse: request accepted, operands latched.
REQ-009 DONE0, DONE1  output  1 each  one-cycle pulse: RES valid for that requester.
REQ-010 RES  output  DATA_W  captured ALU result, held until next capture.
REQ-011 ALU_DATA1, ALU_DATA2  output  DATA_W  registered operands to shared ALU.
REQ-012 ALU_SELECT  output  3  registered function select to shared ALU.
REQ-013 ALU_RESULT  input  DATA_W  shared ALU result.
REQ-014 BUSY  output  1  high in every state except IDLE.

Function
REQ-015 FSM states SHALL be IDLE, WAIT, CAPTURE; exactly one operation in flight.
REQ-016 REQx SHALL be sampled only in IDLE; at accepting edge t0: winner's OPA/OPB/SEL latched onto ALU_DATA1/ALU_DATA2/ALU_SELECT, ACKx high for the following cycle, counter loaded with ALU_WAIT, go WAIT.
REQ-017 WAIT SHALL decrement counter each edge; at counter==1 go CAPTURE (WAIT lasts exactly ALU_WAIT cycles).
REQ-018 CAPTURE edge (t0+ALU_WAIT+1) SHALL load RES from ALU_RESULT, pulse DONEx for the granted requester one cycle, go IDLE.
REQ-019 ALU_DATA1/2, ALU_SELECT SHALL stay stable from t0 until the CAPTURE edge.
REQ-020 Simultaneous REQ0 and REQ1: grant the requester not granted last (round-robin); lone request always granted.
REQ-021 REQx dropped after ACKx SHALL NOT cancel the operation; DONEx still pulses.
REQ-022 REQx dropped before acceptance: no grant, no ACK.
REQ-023 REQx held high through DONEx SHALL be re-accepted at the next edge (IDLE), giving back-to-back throughput of one op per ALU_WAIT+2 cycles; round-robin alternates under continuous dual requests.
REQ-024 ACK0/ACK1 and DONE0/DONE1 SHALL never be high together.

Reset
REQ-025 RESET_N low SHALL immediately force IDLE, counter 0, ACKx/DONEx/BUSY 0, RES/ALU_DATA1/ALU_DATA2/ALU_SELECT 0, round-robin pointer = last-granted 1 (requester 0 first).
REQ-026 Reset mid-operation SHALL abandon the in-flight op with no DONE pulse after release.
REQ-027 First acceptance SHALL occur no earlier than the first rising edge after RESET_N deasserts.

Configuration
REQ-028 Macro ALU_ARB_FIXED_PRIO_EN defined: requester 0 always wins simultaneous requests, pointer unused; undefined: round-robin per REQ-020.

Structure
REQ-029 Package alu_arb_pkg SHALL hold FSM state enum, SEL width constant (3), ALU function codes.
REQ-030 Grant selection SHALL be sub-module alu_arb_grant (REQ0/REQ1/pointer in, one-hot grant out, combinational).

Verification
REQ-031 REQ0=1, OPA0=8'hF0, OPB0=8'h3C, SEL0=AND, ALU_WAIT=1 -> ACK0 cycle after t0, DONE0 at t0+2 with RES=8'h30.
REQ-032 REQ0 and REQ1 raised same edge after reset -> ACK0 first, then ACK1 after DONE0; continuous both -> grants alternate 0,1,0,1.
REQ-033 ALU_WAIT=4 -> ALU_DATA1/2 stable 4 WAIT cycles, DONE exactly 5 edges after acceptance.
REQ-034 RESET_N low in WAIT -> all outputs 0 asynchronously, no DONE after release.
REQ-035 REQ1 dropped the cycle after ACK1 -> DONE1 still pulses with correct RES.
REQ-036 ALU_ARB_FIXED_PRIO_EN defined, both requesting continuously -> only requester 0 granted.
